// File: rtl/led_pkg.sv
// Shared constants for the memory-mapped LED controller: channel mode encodings,
// register word offsets (DataAdr[6:2]) and CTRL bit positions.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF    = 2'b00,
    LED_DIRECT = 2'b01,
    LED_BLINK  = 2'b10,
    LED_PWM    = 2'b11
  } led_mode_e;

  // Word offsets, i.e. byte offset >> 2.
  localparam logic [4:0] OFF_CTRL     = 5'd0;
  localparam logic [4:0] OFF_PRESCALE = 5'd1;
  localparam logic [4:0] OFF_DATA     = 5'd2;
  localparam logic [4:0] OFF_MODE     = 5'd3;
  localparam logic [4:0] OFF_DUTY0    = 5'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/mmio_led_ctrl_if.sv
// CPU data-bus view of the LED peripheral: store strobe, address, store data,
// plus the combinational readback and window-hit returned to the CPU top.
interface mmio_led_ctrl_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData, hit);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, hit);
endinterface

// File: rtl/led_timebase.sv
// Shared timebase: programmable prescaler that ticks a free-running PWM counter,
// with a blink phase that flips each time the PWM counter wraps.
module led_timebase #(
  parameter int PRESC_W  = 24,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [PRESC_W-1:0]  prescale,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                blink_ph
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  // ">=" rather than "==" so lowering PRESCALE below the count ticks at once.
  assign tick = en && (presc_cnt >= prescale);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      blink_ph  <= 1'b0;
    end else if (clr) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      blink_ph  <= 1'b0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (&pwm_cnt) blink_ph <= ~blink_ph;
    end else if (en) begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED/GPIO peripheral: CTRL/PRESCALE/DATA/MODE/DUTY registers,
// per-channel OFF/DIRECT/BLINK/PWM muxes, registered led. Define LED_READBACK_EN
// to enable register readback; otherwise ReadData is tied to 0.
module mmio_led_ctrl
  import led_pkg::*;
#(
  parameter int          N_LED     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          PRESC_W   = 24,
  parameter int          PWM_BITS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  mmio_led_ctrl_if.slave    bus,
  output logic [N_LED-1:0]  led
);

  logic                 en_q;
  logic [PRESC_W-1:0]   prescale_q;
  logic [N_LED-1:0]     data_q;
  logic [2*N_LED-1:0]   mode_q;
  logic [PWM_BITS-1:0]  duty_q [N_LED];

  logic [4:0]           offset;
  logic                 wr;
  logic                 clr;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 blink_ph;
  logic [N_LED-1:0]     led_nxt;
  logic                 unused_bits;

  assign offset      = bus.DataAdr[6:2];
  assign bus.hit     = (bus.DataAdr[31:7] == BASE_ADDR[31:7]);
  assign wr          = bus.MemWrite && bus.hit;
  assign clr         = wr && (offset == OFF_CTRL) && bus.WriteData[CTRL_CLR];
  assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData};

  // NOTE: the DUTY array is a handful of flops, not a RAM, so it is reset
  // together with the other registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      data_q     <= '0;
      mode_q     <= '0;
      for (int i = 0; i < N_LED; i++) duty_q[i] <= '0;
    end else if (wr) begin
      case (offset)
        OFF_CTRL:     en_q       <= bus.WriteData[CTRL_EN];
        OFF_PRESCALE: prescale_q <= bus.WriteData[PRESC_W-1:0];
        OFF_DATA:     data_q     <= bus.WriteData[N_LED-1:0];
        OFF_MODE:     mode_q     <= bus.WriteData[2*N_LED-1:0];
        default: begin
          for (int i = 0; i < N_LED; i++)
            if (offset == OFF_DUTY0 + 5'(i)) duty_q[i] <= bus.WriteData[PWM_BITS-1:0];
        end
      endcase
    end
  end

  led_timebase #(
    .PRESC_W  (PRESC_W),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .en       (en_q),
    .clr      (clr),
    .prescale (prescale_q),
    .pwm_cnt  (pwm_cnt),
    .blink_ph (blink_ph)
  );

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    led_mode_e mode;
    assign mode       = led_mode_e'(mode_q[2*g +: 2]);
    assign led_nxt[g] = (mode == LED_DIRECT) ? data_q[g] :
                        (mode == LED_BLINK)  ? (data_q[g] & blink_ph) :
                        (mode == LED_PWM)    ? (pwm_cnt < duty_q[g]) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) led <= '0;
    else       led <= en_q ? led_nxt : '0;
  end

`ifdef LED_READBACK_EN
  logic [31:0] rdata;

  // NOTE: rdata gets a full default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (bus.hit) begin
      case (offset)
        OFF_CTRL:     rdata[CTRL_EN]        = en_q;
        OFF_PRESCALE: rdata[PRESC_W-1:0]    = prescale_q;
        OFF_DATA:     rdata[N_LED-1:0]      = data_q;
        OFF_MODE:     rdata[2*N_LED-1:0]    = mode_q;
        default: begin
          for (int i = 0; i < N_LED; i++)
            if (offset == OFF_DUTY0 + 5'(i)) rdata[PWM_BITS-1:0] = duty_q[i];
        end
      endcase
    end
  end

  assign bus.ReadData = rdata;
`else
  assign bus.ReadData = '0;
`endif

endmodule
